key_counter_multi: RTL

- Parametrised multi-key front end: per-key synchroniser, bidirectional debounce, press and long-press events with auto-repeat.
- Drives a modulo up/down counter and a one-hot LED decode.
- Successor to the single-key press counter. Sits between board push-buttons and the LED bank; key events are also exported for other consumers.

---
 rtl/key_counter_multi_if.sv | 25 ++
 rtl/key_counter_multi.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/key_counter_multi_if.sv
// Key front-end bundle: raw active-low keys in, debounced levels, event pulses and counter/LED out.
// master drives the raw keys and observes the results; slave is the key_counter_multi side.
interface key_counter_multi_if #(
  parameter int NUM_KEYS = 3,
  parameter int CNT_W    = 4,
  parameter int LED_W    = 8
);
  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] key_rpt;
  logic [CNT_W-1:0]    cnt;
  logic [LED_W-1:0]    led;

  modport master (
    output key,
    input  key_state, key_press, key_long, key_rpt, cnt, led
  );

  modport slave (
    input  key,
    output key_state, key_press, key_long, key_rpt, cnt, led
  );
endinterface

// File: rtl/key_counter_multi.sv
// Multi-key front end: 2-FF sync, two-way debounce, press/long/auto-repeat pulses, mod-N up/down counter, LED decode.
// Latency: press pulse 2+DEB_CYCLES clocks after the raw edge, cnt one clock later, led one more; no backpressure.
module key_counter_multi #(
  parameter int NUM_KEYS      = 3,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_MOD       = 10,
  parameter int LED_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  key_counter_multi_if.slave kif
);

  localparam int CNT_W  = (CNT_MOD > 1)       ? $clog2(CNT_MOD)       : 1;
  localparam int DEB_W  = (DEB_CYCLES > 1)    ? $clog2(DEB_CYCLES)    : 1;
  localparam int HOLD_W = (LONG_CYCLES > 1)   ? $clog2(LONG_CYCLES)   : 1;
  localparam int RPT_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CNT_MOD - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_key_state;
  logic [NUM_KEYS-1:0] w_key_press;
  logic [NUM_KEYS-1:0] w_key_long;
  logic [NUM_KEYS-1:0] w_key_rpt;
  logic [CNT_W-1:0]    r_cnt;
  logic [LED_W-1:0]    r_led;
  logic [LED_W-1:0]    w_led;
  logic                w_up;
  logic                w_down;
  logic                w_clr;

  // Sync stages reset to the released (high) level so a held key re-debounces after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= kif.key;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic              r_state;
    logic              r_press;
    logic              r_long;
    logic              r_rpt;
    logic              r_long_done;
    logic [DEB_W-1:0]  r_deb;
    logic [HOLD_W-1:0] r_hold;
    logic [RPT_W-1:0]  r_rpt_cnt;
    logic              w_s;
    logic              w_toggle;
    logic              w_long_hit;
    logic              w_rpt_hit;

    assign w_s        = ~r_sync2[g];
    assign w_toggle   = (w_s != r_state) && (r_deb == DEB_LAST);
    assign w_long_hit = (r_hold == HOLD_LAST);
    assign w_rpt_hit  = (r_rpt_cnt == RPT_LAST);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state     <= 1'b0;
        r_press     <= 1'b0;
        r_long      <= 1'b0;
        r_rpt       <= 1'b0;
        r_long_done <= 1'b0;
        r_deb       <= '0;
        r_hold      <= '0;
        r_rpt_cnt   <= '0;
      end else begin
        r_press <= w_toggle & ~r_state;
        r_long  <= 1'b0;
        r_rpt   <= 1'b0;

        if ((w_s == r_state) || w_toggle) begin
          r_deb <= '0;
        end else begin
          r_deb <= r_deb + DEB_W'(1);
        end

        if (w_toggle) begin
          r_state <= ~r_state;
        end

        // A release landing on a pulse edge takes this branch, which suppresses the pulse.
        if (!r_state || w_toggle) begin
          r_hold      <= '0;
          r_rpt_cnt   <= '0;
          r_long_done <= 1'b0;
        end else if (!r_long_done) begin
          if (w_long_hit) begin
            r_long      <= 1'b1;
            r_long_done <= 1'b1;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end else if (w_rpt_hit) begin
          r_rpt     <= 1'b1;
          r_rpt_cnt <= '0;
        end else begin
          r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
        end
      end
    end

    assign w_key_state[g] = r_state;
    assign w_key_press[g] = r_press;
    assign w_key_long[g]  = r_long;
    assign w_key_rpt[g]   = r_rpt;
  end

  assign w_up   = w_key_press[0] | w_key_rpt[0];
  assign w_down = w_key_press[1] | w_key_rpt[1];

  if (NUM_KEYS >= 3) begin : g_clr
    assign w_clr = w_key_press[2];
  end else begin : g_no_clr
    assign w_clr = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
    end else if (w_up && !w_down) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
    end else if (w_down && !w_up) begin
      r_cnt <= (r_cnt == '0) ? CNT_MAX : r_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_led = '0;
    if (int'(r_cnt) > LED_W) begin
      w_led = '1;
    end else begin
      for (int i = 0; i < LED_W; i++) begin
        if (int'(r_cnt) == i + 1) begin
          w_led[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
    end else begin
      r_led <= w_led;
    end
  end

  assign kif.key_state = w_key_state;
  assign kif.key_press = w_key_press;
  assign kif.key_long  = w_key_long;
  assign kif.key_rpt   = w_key_rpt;
  assign kif.cnt       = r_cnt;
  assign kif.led       = r_led;

endmodule
